// File: rtl/byte_pair_tx_pkg.sv
`default_nettype none
// ============================================================================
// Module   : byte_pair_tx_pkg
// Purpose  : Shared definitions for the byte-pair serial transmitter:
//            FSM state encodings, frame geometry, default bit period and
//            the parity helper.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package byte_pair_tx_pkg;

    // FSM state encodings
    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
    localparam logic [2:0] S_PARITY = 3'd3;
    localparam logic [2:0] S_STOP   = 3'd4;

    localparam int DATA_BITS            = 8;
    localparam int CLKS_PER_BIT_DEFAULT = 4;
    localparam int TIMER_W              = 16;

    // Even parity: the parity bit makes the total count of ones even.
    function automatic logic even_parity(input logic [7:0] b);
        return ^b;
    endfunction

endpackage
`default_nettype wire

// File: rtl/byte_pair_tx_if.sv
`default_nettype none
// ============================================================================
// Module   : byte_pair_tx_if
// Purpose  : Bundles the pair-handshake and serial-side signals of the
//            byte-pair transmitter.
// Signals  : in_valid/in_ready  pair handshake
//            num1/num2          operand bytes (num1 sent first)
//            tx                 serial line, idles high
//            busy               transfer in progress
//            done               one-cycle completion pulse
// Modports : master - pair source / line observer
//            slave  - the transmitter
// Revision : 1.0 - initial release
// ============================================================================
interface byte_pair_tx_if;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] num1;
    logic [7:0] num2;
    logic       tx;
    logic       busy;
    logic       done;

    modport master (
        output in_valid, num1, num2,
        input  in_ready, tx, busy, done
    );

    modport slave (
        input  in_valid, num1, num2,
        output in_ready, tx, busy, done
    );
endinterface
`default_nettype wire

// File: rtl/byte_pair_tx_bit_timer.sv
`default_nettype none
// ============================================================================
// Module   : bit_timer
// Purpose  : Down-counter that times one serial bit. Loaded with
//            CLKS_PER_BIT-1 on restart or when it expires; tick_o marks the
//            last cycle of each bit period.
// Ports    : clk        clock
//            reset      synchronous active-high reset
//            restart_i  reload the counter (new FSM state)
//            tick_o     last cycle of the current bit
// Revision : 1.0 - initial release
// ============================================================================
module bit_timer
    import byte_pair_tx_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT
) (
    input  wire logic clk,
    input  wire logic reset,
    input  wire logic restart_i,
    output logic      tick_o
);

    localparam logic [TIMER_W-1:0] RELOAD = TIMER_W'(CLKS_PER_BIT - 1);

    logic [TIMER_W-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else if (restart_i || (cnt_q == '0)) begin
            cnt_q <= RELOAD;
        end else begin
            cnt_q <= cnt_q - 1'b1;
        end
    end

    assign tick_o = (cnt_q == '0);

endmodule
`default_nettype wire

// File: rtl/byte_pair_tx.sv
`default_nettype none
// ============================================================================
// Module   : byte_pair_tx
// Purpose  : Accepts an operand pair in one valid/ready handshake and sends
//            it as two back-to-back UART-style frames (num1 first, LSB
//            first): start(0), 8 data bits, optional even parity, stop(1).
// Ports    : clk    clock, rising edge
//            reset  synchronous active-high reset
//            bus    byte_pair_tx_if.slave (in_valid, in_ready, num1, num2,
//                   tx, busy, done)
// Revision : 1.0 - initial release
// ============================================================================
module byte_pair_tx
    import byte_pair_tx_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT,
    parameter int PARITY_EN    = 1
) (
    input  wire logic     clk,
    input  wire logic     reset,
    byte_pair_tx_if.slave bus
);

    localparam logic [2:0] LAST_BIT = 3'(DATA_BITS - 1);

    logic [2:0]  state_q, state_d;
    logic        sel_q, sel_d;
    logic [2:0]  bit_cnt_q, bit_cnt_d;
    logic [15:0] shadow_q, shadow_d;
    logic        tx_q, tx_d;
    logic [7:0]  byte_d;
    logic        tick;
    logic        restart;
    logic        accept;

    // Every state change restarts the bit period; within DATA the timer
    // reloads itself on expiry so consecutive data bits line up.
    assign restart = (state_d != state_q);

    bit_timer #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_bit_timer (
        .clk       (clk),
        .reset     (reset),
        .restart_i (restart),
        .tick_o    (tick)
    );

    // ---------------- state register ----------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            sel_q     <= 1'b0;
            bit_cnt_q <= 3'd0;
            shadow_q  <= 16'd0;
            tx_q      <= 1'b1;
        end else begin
            state_q   <= state_d;
            sel_q     <= sel_d;
            bit_cnt_q <= bit_cnt_d;
            shadow_q  <= shadow_d;
            tx_q      <= tx_d;
        end
    end

    // ---------------- next-state logic ----------------
    always_comb begin
        state_d   = state_q;
        sel_d     = sel_q;
        bit_cnt_d = bit_cnt_q;
        shadow_d  = shadow_q;
        accept    = bus.in_valid && (state_q == S_IDLE);

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    shadow_d  = {bus.num2, bus.num1};
                    state_d   = S_START;
                    sel_d     = 1'b0;
                    bit_cnt_d = 3'd0;
                end
            end
            S_START: begin
                if (tick) begin
                    state_d = S_DATA;
                end
            end
            S_DATA: begin
                if (tick) begin
                    // 3-bit counter wraps 7->0 on the way out of DATA
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == LAST_BIT) begin
                        state_d = (PARITY_EN != 0) ? S_PARITY : S_STOP;
                    end
                end
            end
            S_PARITY: begin
                if (tick) begin
                    state_d = S_STOP;
                end
            end
            S_STOP: begin
                if (tick) begin
                    if (!sel_q) begin
                        state_d = S_START;
                        sel_d   = 1'b1;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // ---------------- output logic ----------------
    // tx is registered: the value loaded here is the one for the state being
    // entered, so the start bit appears right after the accept edge.
    always_comb begin
        byte_d = sel_d ? shadow_d[15:8] : shadow_d[7:0];
        tx_d   = 1'b1;
        case (state_d)
            S_START:  tx_d = 1'b0;
            S_DATA:   tx_d = byte_d[bit_cnt_d];
            S_PARITY: tx_d = even_parity(byte_d);
            default:  tx_d = 1'b1;
        endcase
    end

    assign bus.tx       = tx_q;
    assign bus.in_ready = (state_q == S_IDLE);
    assign bus.busy     = (state_q != S_IDLE);
    assign bus.done     = (state_q == S_STOP) && sel_q && tick;

endmodule
`default_nettype wire

// File: tb/tb_byte_pair_tx.sv
`default_nettype none
// ============================================================================
// Module   : tb_byte_pair_tx
// Purpose  : Directed self-checking bench for byte_pair_tx. Three instances
//            cover CLKS_PER_BIT/PARITY_EN = 4/1, 1/0 and 2/1. Expected line
//            bit sequences are hand-written tables in send order.
// Revision : 1.0 - initial release
// ============================================================================
module tb_byte_pair_tx;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    byte_pair_tx_if if_a ();
    byte_pair_tx_if if_b ();
    byte_pair_tx_if if_c ();

    byte_pair_tx #(.CLKS_PER_BIT(4), .PARITY_EN(1)) u_dut_a (.clk(clk), .reset(reset), .bus(if_a));
    byte_pair_tx #(.CLKS_PER_BIT(1), .PARITY_EN(0)) u_dut_b (.clk(clk), .reset(reset), .bus(if_b));
    byte_pair_tx #(.CLKS_PER_BIT(2), .PARITY_EN(1)) u_dut_c (.clk(clk), .reset(reset), .bus(if_c));

    int n_vec  = 0;
    int n_miss = 0;
    bit exp_bits[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // {tx, busy, in_ready, done} of the selected instance
    function automatic logic [3:0] sample(input int w);
        case (w)
            0:       return {if_a.tx, if_a.busy, if_a.in_ready, if_a.done};
            1:       return {if_b.tx, if_b.busy, if_b.in_ready, if_b.done};
            default: return {if_c.tx, if_c.busy, if_c.in_ready, if_c.done};
        endcase
    endfunction

    task automatic drive(input int w, input logic v, input logic [7:0] a, input logic [7:0] b);
        case (w)
            0:       begin if_a.in_valid = v; if_a.num1 = a; if_a.num2 = b; end
            1:       begin if_b.in_valid = v; if_b.num1 = a; if_b.num2 = b; end
            default: begin if_c.in_valid = v; if_c.num1 = a; if_c.num2 = b; end
        endcase
    endtask

    // Called at a negedge; returns at the negedge right after the accept edge.
    task automatic accept(input int w, input logic [7:0] a, input logic [7:0] b, input bit keep);
        logic [3:0] s;
        int t;
        drive(w, 1'b1, a, b);
        t = 0;
        s = sample(w);
        while (!s[1] && t < 200) begin
            @(negedge clk);
            t++;
            s = sample(w);
        end
        if (t >= 200) check("accept_timeout", 32'd0, 32'd1);
        @(negedge clk);
        if (!keep) drive(w, 1'b0, a, b);
    endtask

    // Walks one full transfer comparing tx every cycle against exp_bits.
    // poke_at >= 0: at that cycle change num1 to FF and pulse in_valid.
    task automatic run_frame(input string tag, input int w, input int cpb, input int poke_at);
        logic [3:0] s;
        int n;
        n = exp_bits.size() * cpb;
        for (int j = 0; j < n; j++) begin
            s = sample(w);
            check($sformatf("%s_tx%0d", tag, j), {31'd0, s[3]}, {31'd0, exp_bits[j / cpb]});
            check($sformatf("%s_done%0d", tag, j), {31'd0, s[0]}, {31'd0, (j == n - 1)});
            if (j == 0) check({tag, "_busy"}, {31'd0, s[2]}, 32'd1);
            if (poke_at >= 0 && j == poke_at)     drive(w, 1'b1, 8'hFF, 8'hFF);
            if (poke_at >= 0 && j == poke_at + 1) drive(w, 1'b0, 8'hFF, 8'hFF);
            @(negedge clk);
        end
    endtask

    task automatic check_idle(input string tag, input int w);
        logic [3:0] s;
        s = sample(w);
        check({tag, "_idle_tx"},    {31'd0, s[3]}, 32'd1);
        check({tag, "_idle_busy"},  {31'd0, s[2]}, 32'd0);
        check({tag, "_idle_ready"}, {31'd0, s[1]}, 32'd1);
        check({tag, "_idle_done"},  {31'd0, s[0]}, 32'd0);
    endtask

    initial begin
        logic [3:0] s;
        int bad;
        int t;
        bit seen;

        drive(0, 1'b0, 8'h00, 8'h00);
        drive(1, 1'b0, 8'h00, 8'h00);
        drive(2, 1'b0, 8'h00, 8'h00);
        reset = 1'b1;
        repeat (3) @(negedge clk);

        // Reset state
        check_idle("rst_a", 0);
        check_idle("rst_b", 1);
        check_idle("rst_c", 2);
        reset = 1'b0;
        @(negedge clk);

        // Reference pair C9/C9, 4 clk/bit, parity on
        exp_bits = '{0,1,0,0,1,0,0,1,1,0,1, 0,1,0,0,1,0,0,1,1,0,1};
        accept(0, 8'hC9, 8'hC9, 1'b0);
        run_frame("ref", 0, 4, -1);
        check_idle("ref_end", 0);

        // Parity off, 1 clk/bit: 01 then 80, 20 cycles
        exp_bits = '{0,1,0,0,0,0,0,0,0,1, 0,0,0,0,0,0,0,0,1,1};
        accept(1, 8'h01, 8'h80, 1'b0);
        run_frame("nopar", 1, 1, -1);
        check_idle("nopar_end", 1);

        // Odd-parity num1 (07 -> parity 1), with num1 changed and in_valid
        // pulsed mid-transfer; A6 has even weight -> parity 0
        exp_bits = '{0,1,1,1,0,0,0,0,0,1,1, 0,0,1,1,0,0,1,0,1,0,1};
        accept(0, 8'h07, 8'hA6, 1'b0);
        run_frame("oddpar", 0, 4, 10);
        check_idle("oddpar_end", 0);
        @(negedge clk);
        check("oddpar_no_restart", {31'd0, sample(0) >> 2 & 4'd1}, 32'd0);

        // Reset during num1 DATA
        accept(0, 8'h5A, 8'h3C, 1'b0);
        repeat (8) @(negedge clk);
        check("rstmid_busy_before", {31'd0, sample(0) >> 2 & 4'd1}, 32'd1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check_idle("rstmid", 0);
        bad = 0;
        for (int j = 0; j < 40; j++) begin
            @(negedge clk);
            s = sample(0);
            if (s[0] || !s[3]) bad++;
        end
        check("rstmid_quiet_cycles", bad, 32'd0);
        exp_bits = '{0,1,0,0,1,0,0,1,1,0,1, 0,1,0,0,1,0,0,1,1,0,1};
        accept(0, 8'hC9, 8'hC9, 1'b0);
        run_frame("rstmid_fresh", 0, 4, -1);
        check_idle("rstmid_fresh_end", 0);

        // Back-to-back with in_valid held, 2 clk/bit, parity on
        exp_bits = '{0,1,0,0,0,0,0,0,0,1,1, 0,0,0,0,0,0,0,0,1,1,1};
        accept(2, 8'h01, 8'h80, 1'b1);
        run_frame("b2b", 2, 2, -1);
        s = sample(2);
        check("b2b_gap_ready", {31'd0, s[1]}, 32'd1);
        check("b2b_gap_tx",    {31'd0, s[3]}, 32'd1);
        @(negedge clk);
        s = sample(2);
        check("b2b_second_start_tx",    {31'd0, s[3]}, 32'd0);
        check("b2b_second_start_ready", {31'd0, s[1]}, 32'd0);
        drive(2, 1'b0, 8'h01, 8'h80);
        seen = 1'b0;
        t = 0;
        while (!seen && t < 100) begin
            s = sample(2);
            if (s[0]) seen = 1'b1;
            @(negedge clk);
            t++;
        end
        check("b2b_second_done", {31'd0, seen}, 32'd1);
        check_idle("b2b_end", 2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
`default_nettype wire
